// File: rtl/fact_pkg.sv
// Shared definitions for the factorial accelerator: register offsets,
// FSM state encoding and the largest operand whose factorial fits in 32 bits.
package fact_pkg;

  // Word offsets within the peripheral window (CPU address bits [3:2])
  localparam logic [1:0] FACT_N   = 2'b00;
  localparam logic [1:0] FACT_GO  = 2'b01;
  localparam logic [1:0] FACT_ST  = 2'b10;
  localparam logic [1:0] FACT_RES = 2'b11;

  // 12! = 479001600 fits in 32 bits, 13! does not
  localparam int MAX_N = 12;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fact_state_e;

endpackage

// File: rtl/fact_core.sv
// Iterative factorial engine: one multiply per RUN cycle, counting cnt down
// from n to 1. Out-of-range operands are rejected at the Go edge with err.
module fact_core #(
  parameter int WIDTH  = 32,
  parameter int NWIDTH = 4,
  parameter int MAX_N  = fact_pkg::MAX_N
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_go,
  input  logic [NWIDTH-1:0] i_n,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [WIDTH-1:0]  o_result
);
  import fact_pkg::*;

  fact_state_e       r_state;
  fact_state_e       w_state_next;
  logic [NWIDTH-1:0] r_cnt;
  logic [NWIDTH-1:0] w_cnt_next;
  logic [WIDTH-1:0]  r_prod;
  logic [WIDTH-1:0]  w_prod_next;
  logic [WIDTH-1:0]  r_result;
  logic [WIDTH-1:0]  w_result_next;
  logic              r_done;
  logic              w_done_next;
  logic              r_err;
  logic              w_err_next;

  logic [WIDTH-1:0]  w_cnt_ext;
  logic [WIDTH-1:0]  w_product;
  logic              w_n_too_big;

  // Widen the counter so the product stays WIDTH bits (truncation is safe for n<=MAX_N)
  assign w_cnt_ext   = WIDTH'(r_cnt);
  assign w_product   = r_prod * w_cnt_ext;
  assign w_n_too_big = (int'(i_n) > MAX_N);

  // State and datapath registers; reset aborts any computation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_prod   <= w_prod_next;
      r_result <= w_result_next;
      r_done   <= w_done_next;
      r_err    <= w_err_next;
    end
  end

  // Next-state and datapath update; Go is only honoured in IDLE
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_prod_next   = r_prod;
    w_result_next = r_result;
    w_done_next   = r_done;
    w_err_next    = r_err;
    case (r_state)
      IDLE: begin
        if (i_go) begin
          if (w_n_too_big) begin
            // Reject without touching result; flags stay sticky until next Go
            w_err_next  = 1'b1;
            w_done_next = 1'b1;
          end else begin
            w_cnt_next   = i_n;
            w_prod_next  = WIDTH'(1);
            w_done_next  = 1'b0;
            w_err_next   = 1'b0;
            w_state_next = RUN;
          end
        end
      end
      RUN: begin
        if (r_cnt > NWIDTH'(1)) begin
          w_prod_next = w_product;
          w_cnt_next  = r_cnt - NWIDTH'(1);
        end else begin
          // cnt of 0 or 1 ends the loop, so 0! and 1! both yield 1
          w_result_next = r_prod;
          w_done_next   = 1'b1;
          w_state_next  = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign o_busy   = (r_state == RUN);
  assign o_done   = r_done;
  assign o_err    = r_err;
  assign o_result = r_result;

endmodule

// File: rtl/fact_accel.sv
// Memory-mapped factorial accelerator: register decode, N operand register,
// Go pulse generation and the combinational read mux around fact_core.
module fact_accel #(
  parameter int WIDTH  = 32,
  parameter int NWIDTH = 4,
  parameter int MAX_N  = fact_pkg::MAX_N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       a,
  input  logic             we,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] rd
);
  import fact_pkg::*;

  logic [NWIDTH-1:0] r_n;
  logic              w_go;
  logic              w_busy;
  logic              w_done;
  logic              w_err;
  logic [WIDTH-1:0]  w_result;

  // A Go request is a write of 1 in bit 0 to the GO offset; the core drops it when busy
  assign w_go = we && (a == FACT_GO) && wd[0];

  // N operand register; may be rewritten while busy without disturbing the run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n <= '0;
    end else if (we && (a == FACT_N)) begin
      r_n <= wd[NWIDTH-1:0];
    end
  end

  fact_core #(
    .WIDTH  (WIDTH),
    .NWIDTH (NWIDTH),
    .MAX_N  (MAX_N)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_go     (w_go),
    .i_n      (r_n),
    .o_busy   (w_busy),
    .o_done   (w_done),
    .o_err    (w_err),
    .o_result (w_result)
  );

  // Side-effect-free read mux; all sources reset to zero
  always_comb begin
    rd = '0;
    case (a)
      FACT_N:   rd = WIDTH'(r_n);
      FACT_GO:  rd = WIDTH'(w_busy);
      FACT_ST:  rd = WIDTH'({w_err, w_done});
      FACT_RES: rd = w_result;
      default:  rd = '0;
    endcase
  end

endmodule

// File: tb/tb_fact_accel.sv
// Directed testbench for fact_accel with hand-computed expected values.
module tb_fact_accel;
  import fact_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [1:0]  a;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;

  int n_checks = 0;
  int n_errors = 0;

  fact_accel #(.WIDTH(32), .NWIDTH(4), .MAX_N(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .we    (we),
    .wd    (wd),
    .rd    (rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  // One bus write: drive at negedge, commit on posedge, return 1ns after it
  task automatic bus_write(input logic [1:0] off, input logic [31:0] data);
    @(negedge clk);
    a  = off;
    wd = data;
    we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
    wd = '0;
  endtask

  task automatic bus_read(input logic [1:0] off, output logic [31:0] data);
    a = off;
    #1;
    data = rd;
  endtask

  task automatic read_check(input string tag, input logic [1:0] off, input logic [31:0] exp);
    logic [31:0] v;
    bus_read(off, v);
    check(tag, v, exp);
  endtask

  // Watch edges 1..lat after the Go edge: busy/done must switch exactly at edge lat
  task automatic watch_run(input string tag, input int lat);
    logic [31:0] st;
    logic [31:0] bz;
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk);
      #1;
      bus_read(FACT_ST, st);
      bus_read(FACT_GO, bz);
      if (k < lat) begin
        if (st !== 32'h0 || bz !== 32'h1) check({tag, "_midrun"}, {st[15:0], bz[15:0]}, 32'h0000_0001);
      end else begin
        check({tag, "_status"}, st, 32'h1);
        check({tag, "_busy_end"}, bz, 32'h0);
      end
    end
  endtask

  initial begin
    a     = FACT_N;
    we    = 1'b0;
    wd    = '0;
    rst_n = 1'b1;

    // Reset asserted mid-cycle: reads must be zero with no clock edge
    #3 rst_n = 1'b0;
    #1;
    read_check("rst_N",   FACT_N,   32'h0);
    read_check("rst_GO",  FACT_GO,  32'h0);
    read_check("rst_ST",  FACT_ST,  32'h0);
    read_check("rst_RES", FACT_RES, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // GO with wd[0]=0 must not start anything
    bus_write(FACT_GO, 32'h0000_0002);
    read_check("go0_busy", FACT_GO, 32'h0);

    // n=5 -> 120 after 5 edges
    bus_write(FACT_N, 32'd5);
    read_check("n5_N", FACT_N, 32'd5);
    bus_write(FACT_GO, 32'd1);
    read_check("n5_busy_E0", FACT_GO, 32'h1);
    watch_run("n5", 5);
    read_check("n5_RES", FACT_RES, 32'd120);

    // Status is sticky and not cleared by reads
    read_check("n5_ST_sticky", FACT_ST, 32'h1);

    // n=12 boundary
    bus_write(FACT_N, 32'd12);
    bus_write(FACT_GO, 32'd1);
    read_check("n12_ST_clr", FACT_ST, 32'h0);
    watch_run("n12", 12);
    read_check("n12_RES", FACT_RES, 32'd479001600);

    // n=0 -> 1 after 1 edge
    bus_write(FACT_N, 32'd0);
    bus_write(FACT_GO, 32'd1);
    watch_run("n0", 1);
    read_check("n0_RES", FACT_RES, 32'd1);

    // n=13 -> err+done at E0, result unchanged, never busy
    bus_write(FACT_N, 32'd13);
    bus_write(FACT_GO, 32'd1);
    read_check("n13_ST", FACT_ST, 32'h3);
    read_check("n13_busy", FACT_GO, 32'h0);
    read_check("n13_RES", FACT_RES, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    read_check("n13_busy_later", FACT_GO, 32'h0);
    read_check("n13_ST_later", FACT_ST, 32'h3);

    // Busy interference: N=3 and GO during a n=6 run
    bus_write(FACT_N, 32'd6);
    bus_write(FACT_GO, 32'd1);          // E0
    read_check("int_ST_clr", FACT_ST, 32'h0);
    bus_write(FACT_N, 32'd3);           // E1
    bus_write(FACT_GO, 32'd1);          // E2, ignored
    read_check("int_busy_E2", FACT_GO, 32'h1);
    for (int k = 3; k <= 6; k++) begin
      logic [31:0] st;
      @(posedge clk);
      #1;
      bus_read(FACT_ST, st);
      if (k < 6) begin
        if (st !== 32'h0) check("int_midrun_ST", st, 32'h0);
      end else begin
        check("int_ST", st, 32'h1);
      end
    end
    read_check("int_RES", FACT_RES, 32'd720);
    read_check("int_N", FACT_N, 32'd3);
    read_check("int_busy_end", FACT_GO, 32'h0);
    bus_write(FACT_GO, 32'd1);
    watch_run("n3", 3);
    read_check("n3_RES", FACT_RES, 32'd6);

    // Reset mid-RUN
    bus_write(FACT_N, 32'd10);
    bus_write(FACT_GO, 32'd1);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    read_check("mid_rst_N",   FACT_N,   32'h0);
    read_check("mid_rst_GO",  FACT_GO,  32'h0);
    read_check("mid_rst_ST",  FACT_ST,  32'h0);
    read_check("mid_rst_RES", FACT_RES, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_write(FACT_N, 32'd4);
    bus_write(FACT_GO, 32'd1);
    watch_run("n4", 4);
    read_check("n4_RES", FACT_RES, 32'd24);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the run always terminates
  initial begin
    #100000;
    n_errors++;
    $display("FAIL timeout got=running exp=finished");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule
